// File: rtl/c_isa_pkg.sv
// Shared RV32C encoding constants and types for the compressed-instruction encoder.
package c_isa_pkg;

  localparam int OP_W  = 4;
  localparam int REG_W = 3;
  localparam int IMM_W = 7;
  localparam int NZ_W  = 6;
  localparam int OFF_W = 9;
  localparam int INS_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_LW   = 4'h0,
    OP_SW   = 4'h1,
    OP_ADD  = 4'h2,
    OP_ADDI = 4'h3,
    OP_AND  = 4'h4,
    OP_ANDI = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_SRAI = 4'h8,
    OP_SLLI = 4'h9,
    OP_BEQZ = 4'hA,
    OP_BNEZ = 4'hB
  } op_e;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b110;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b000;
  localparam logic [2:0] F3_ALU  = 3'b100;
  localparam logic [2:0] F3_BEQZ = 3'b110;
  localparam logic [2:0] F3_BNEZ = 3'b111;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [INS_W-1:0] C_NOP = 16'h0001;

endpackage

// File: rtl/c_instr_pack.sv
// Combinational packer: decoded fields to one 16-bit RV32C word plus
// an illegal flag; illegal bundles yield c.nop.
module c_instr_pack
  import c_isa_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [IMM_W-1:0] immediate,
  input  logic [NZ_W-1:0]  nzimm,
  input  logic [OFF_W-1:0] offset,
  output logic [INS_W-1:0] word,
  output logic             illegal
);

  op_e op;
  logic [INS_W-1:0] w;

  assign op = op_e'(opcode);

  always_comb begin
    w       = '0;
    illegal = 1'b0;
    unique case (op)
      OP_LW, OP_SW: begin
        w[15:13] = (op == OP_LW) ? F3_LW : F3_SW;
        w[1:0]   = Q0;
        w[12]    = immediate[5];
        w[11:10] = immediate[4:3];
        w[9:7]   = rs1;
        w[6]     = immediate[2];
        w[5]     = immediate[6];
        w[4:2]   = (op == OP_LW) ? rd : rs2;
        illegal  = |immediate[1:0];
      end
      OP_ADD: begin
        w[15:13] = F3_ALU;
        w[11:10] = 2'b01;
        w[9:7]   = rd;
        w[4:2]   = rs2;
        w[1:0]   = Q2;
      end
      OP_ADDI, OP_SLLI, OP_SRAI: begin
        w[15:13] = (op == OP_SRAI) ? F3_ALU :
                   (op == OP_SLLI) ? F3_SLLI : F3_ADDI;
        w[1:0]   = (op == OP_SLLI) ? Q2 : Q1;
        w[11:10] = (op == OP_SRAI) ? 2'b01 : 2'b00;
        w[12]    = nzimm[5];
        w[9:7]   = rd;
        w[6:5]   = nzimm[4:3];
        w[4:2]   = nzimm[2:0];
      end
      OP_ANDI: begin
        w[15:13] = F3_ALU;
        w[1:0]   = Q1;
        w[12]    = immediate[5];
        w[11:10] = 2'b10;
        w[9:7]   = rd;
        w[6:5]   = immediate[4:3];
        w[4:2]   = immediate[2:0];
        illegal  = immediate[6];
      end
      OP_AND, OP_OR, OP_XOR: begin
        w[15:13] = F3_ALU;
        w[1:0]   = Q1;
        w[11:10] = 2'b11;
        w[9:7]   = rd;
        w[6:5]   = (op == OP_AND) ? 2'b11 :
                   (op == OP_OR)  ? 2'b10 : 2'b01;
        w[4:2]   = rs2;
      end
      OP_BEQZ, OP_BNEZ: begin
        w[15:13] = (op == OP_BEQZ) ? F3_BEQZ : F3_BNEZ;
        w[1:0]   = Q1;
        w[12]    = offset[8];
        w[11:10] = offset[3:2];
        w[9:7]   = rs1;
        w[6:5]   = offset[6:5];
        w[4:3]   = offset[1:0];
        w[2]     = offset[4];
        illegal  = offset[8] ^ offset[7];
      end
      default: illegal = 1'b1;
    endcase
    word = illegal ? C_NOP : w;
  end

endmodule

// File: rtl/c_instr_encoder.sv
// Streaming RV32C encoder writing packed words to imem at rising addresses.
// Optional C_ENC_ABORT_ON_ERR_EN: stop the stream on the first illegal bundle.
module c_instr_encoder
  import c_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [NZ_W-1:0]   nzimm,
  input  logic [OFF_W-1:0]  offset,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INS_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_count,
  output logic              aborted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [INS_W-1:0]  word;
  logic              illegal;
  logic              xfer;
  logic              stop_hit;

  c_instr_pack u_pack (
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .immediate (immediate),
    .nzimm     (nzimm),
    .offset    (offset),
    .word      (word),
    .illegal   (illegal)
  );

  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN);
  assign xfer     = in_valid && in_ready;

`ifdef C_ENC_ABORT_ON_ERR_EN
  assign stop_hit = illegal;
`else
  assign stop_hit = 1'b0;
  assign aborted  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (length == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (xfer && (remaining == ADDR_W'(1) || stop_hit))
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err_count <= '0;
`ifdef C_ENC_ABORT_ON_ERR_EN
      aborted   <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= (state_nx == S_DONE) && (state != S_DONE);
      if (state == S_IDLE && start) begin
        addr      <= base_addr;
        remaining <= length;
        err_count <= '0;
`ifdef C_ENC_ABORT_ON_ERR_EN
        aborted   <= 1'b0;
`endif
      end else if (xfer) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
        if (illegal && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
`ifdef C_ENC_ABORT_ON_ERR_EN
        // the offending bundle is swallowed, not replaced by c.nop
        if (illegal) begin
          aborted <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= word;
        end
`else
        wr_en   <= 1'b1;
        wr_addr <= addr;
        wr_data <= word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_c_instr_encoder.sv
// Table-driven, scoreboarded bench for c_instr_encoder.
// Expected words are derived by hand from the RV32C field placement.
module tb_c_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  length;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [6:0]  immediate;
  logic [5:0]  nzimm;
  logic [8:0]  offset;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [7:0]  err_count;
  logic        aborted;

  c_instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .immediate(immediate), .nzimm(nzimm), .offset(offset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_count(err_count),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [6:0]  imm;
    logic [5:0]  nz;
    logic [8:0]  off;
    logic [15:0] exp;
    logic        ill;
  } vec_t;

  vec_t vecs[16];
  logic [23:0] sb[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int consec = 0;
  int cyc = 0;
  int last_wr_cyc = -10;

  function automatic vec_t mk(
    input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
    input logic [2:0] s2, input logic [6:0] im, input logic [5:0] nz,
    input logic [8:0] of, input logic [15:0] e, input logic il);
    vec_t v;
    v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.imm = im; v.nz = nz; v.off = of; v.exp = e; v.ill = il;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      wr_cnt++;
      if (cyc == last_wr_cyc + 1) consec++;
      last_wr_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h", wr_addr, wr_data);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write: got %h/%h expected %h/%h",
                   wr_addr, wr_data, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [7:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive(input vec_t v, inout logic [7:0] a);
    int n;
    opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    immediate = v.imm; nzimm = v.nz; offset = v.off;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      sb.push_back({a, v.exp});
      a = a + 8'd1;
      #1;
    end
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 50) begin
      @(posedge clk); n++;
    end
    chk("done_seen", 32'(done_cnt > d0), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a;
    int d0, n_ok, n_ill;
    vec_t v;

    vecs[0]  = mk(4'h2, 3'd3, 3'd0, 3'd5, 7'h00, 6'h00, 9'h000, 16'h8596, 1'b0);
    vecs[1]  = mk(4'h0, 3'd2, 3'd1, 3'd0, 7'h44, 6'h00, 9'h000, 16'h40E8, 1'b0);
    vecs[2]  = mk(4'hA, 3'd0, 3'd4, 3'd0, 7'h00, 6'h00, 9'h1F6, 16'hD675, 1'b0);
    vecs[3]  = mk(4'h1, 3'd0, 3'd2, 3'd3, 7'h08, 6'h00, 9'h000, 16'hC50C, 1'b0);
    vecs[4]  = mk(4'h3, 3'd1, 3'd6, 3'd0, 7'h00, 6'h21, 9'h000, 16'h1085, 1'b0);
    vecs[5]  = mk(4'h9, 3'd7, 3'd0, 3'd0, 7'h00, 6'h1F, 9'h000, 16'h03FE, 1'b0);
    vecs[6]  = mk(4'h8, 3'd2, 3'd0, 3'd0, 7'h00, 6'h03, 9'h000, 16'h850D, 1'b0);
    vecs[7]  = mk(4'h5, 3'd5, 3'd0, 3'd0, 7'h3A, 6'h00, 9'h000, 16'h9AE9, 1'b0);
    vecs[8]  = mk(4'h4, 3'd1, 3'd0, 3'd2, 7'h00, 6'h00, 9'h000, 16'h8CE9, 1'b0);
    vecs[9]  = mk(4'h6, 3'd3, 3'd0, 3'd4, 7'h00, 6'h00, 9'h000, 16'h8DD1, 1'b0);
    vecs[10] = mk(4'h7, 3'd6, 3'd0, 3'd7, 7'h00, 6'h00, 9'h000, 16'h8F3D, 1'b0);
    vecs[11] = mk(4'hB, 3'd0, 3'd3, 3'd0, 7'h00, 6'h00, 9'h02A, 16'hE9B1, 1'b0);
    vecs[12] = mk(4'hC, 3'd1, 3'd1, 3'd1, 7'h00, 6'h00, 9'h000, 16'h0001, 1'b1);
    vecs[13] = mk(4'h5, 3'd1, 3'd0, 3'd0, 7'h40, 6'h00, 9'h000, 16'h0001, 1'b1);
    vecs[14] = mk(4'hA, 3'd0, 3'd2, 3'd0, 7'h00, 6'h00, 9'h080, 16'h0001, 1'b1);
    vecs[15] = mk(4'h0, 3'd1, 3'd1, 3'd0, 7'h02, 6'h00, 9'h000, 16'h0001, 1'b1);

    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    immediate = '0; nzimm = '0; offset = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_aborted", 32'(aborted), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single add at 0x10
    d0 = done_cnt;
    do_start(8'h10, 8'd1);
    chk("busy_run", 32'(busy), 1);
    a = 8'h10;
    drive(vecs[0], a);
    in_valid = 1'b0;
    chk("done_with_last_wr", 32'({done, wr_en}), 32'h3);
    wait_done(d0);

    // whole table as one stream
    n_ok = 0; n_ill = 0;
    for (int i = 0; i < 16; i++) begin
`ifdef C_ENC_ABORT_ON_ERR_EN
      if (!vecs[i].ill) n_ok++;
`else
      n_ok++;
      if (vecs[i].ill) n_ill++;
`endif
    end
    d0 = done_cnt;
    do_start(8'h20, 8'(n_ok));
    a = 8'h20;
    for (int i = 0; i < 16; i++) begin
`ifdef C_ENC_ABORT_ON_ERR_EN
      if (!vecs[i].ill) drive(vecs[i], a);
`else
      drive(vecs[i], a);
`endif
    end
    in_valid = 1'b0;
    wait_done(d0);
    chk("table_err_count", 32'(err_count), 32'(n_ill));
    chk("table_sb_empty", 32'(sb.size()), 0);

    // length 0 goes straight to DONE
    d0 = done_cnt;
    wr_cnt = 0;
    do_start(8'h33, 8'd0);
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("len0_no_writes", 32'(wr_cnt), 0);

    // illegal sw in middle of a 3-slot stream
    d0 = done_cnt;
    wr_cnt = 0;
    do_start(8'h50, 8'd3);
    a = 8'h50;
    drive(vecs[1], a);
    v = mk(4'h1, 3'd0, 3'd1, 3'd2, 7'h05, 6'h00, 9'h000, 16'h0001, 1'b1);
`ifdef C_ENC_ABORT_ON_ERR_EN
    opcode = v.op; rs1 = v.rs1; rs2 = v.rs2; immediate = v.imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(d0);
    chk("abort_writes", 32'(wr_cnt), 1);
    chk("abort_flag", 32'(aborted), 1);
    chk("abort_err", 32'(err_count), 1);
`else
    drive(v, a);
    drive(vecs[0], a);
    in_valid = 1'b0;
    wait_done(d0);
    chk("sw_writes", 32'(wr_cnt), 3);
    chk("sw_err", 32'(err_count), 1);
    chk("sw_aborted", 32'(aborted), 0);
`endif

    // address wrap at full rate
    d0 = done_cnt;
    wr_cnt = 0;
    consec = 0;
    do_start(8'hFE, 8'd4);
    chk("start_clears_err", 32'(err_count), 0);
    chk("start_clears_abort", 32'(aborted), 0);
    a = 8'hFE;
    for (int i = 0; i < 4; i++) drive(vecs[8], a);
    chk("ready_low_after_4", 32'(in_ready), 0);
    in_valid = 1'b0;
    wait_done(d0);
    chk("wrap_writes", 32'(wr_cnt), 4);
    chk("wrap_consecutive", 32'(consec), 3);

    // reset after 2 of 5 transfers
    d0 = done_cnt;
    do_start(8'h60, 8'd5);
    a = 8'h60;
    drive(vecs[2], a);
    drive(vecs[3], a);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 0);
    chk("mid_rst_wr_data", 32'(wr_data), 0);
    chk("mid_rst_busy", 32'({busy, in_ready}), 0);
    sb.delete();
    void'(sb.size());
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 32'(done_cnt), 32'(d0));

    d0 = done_cnt;
    do_start(8'h70, 8'd1);
    a = 8'h70;
    drive(vecs[11], a);
    in_valid = 1'b0;
    wait_done(d0);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
